// File: rtl/instruction_decode_if.sv
// ID-stage bus: fetch-side and writeback inputs plus the registered ID/EX bundle.
// The slave modport is the decode stage; the master modport is whatever drives it.
interface instruction_decode_if;
  logic        clk_en, flush;
  logic [31:0] if_inst, if_pc;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_req, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [3:0]  id_alu_op;
  logic        id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read, id_mem_write;
  logic        id_branch, id_jal, id_jalr, illegal_inst;

  modport slave (
    input  clk_en, flush, if_inst, if_pc, wb_en, wb_rd, wb_data,
    output stall_req, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_alu_op, id_alu_src_a, id_alu_src_b,
           id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr, illegal_inst
  );
  modport master (
    output clk_en, flush, if_inst, if_pc, wb_en, wb_rd, wb_data,
    input  stall_req, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1, id_rs2, id_rd, id_funct3, id_alu_op, id_alu_src_a, id_alu_src_b,
           id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr, illegal_inst
  );
endinterface

// File: rtl/instruction_decode.sv
// RV32I decode stage: register file with write-first bypass, immediate generation,
// control decode, load-use hazard detection and the registered ID/EX boundary.
module instruction_decode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_decode_if.slave  id_bus
);
  localparam logic [6:0] OPC_OP = 7'h33, OPC_OPIMM = 7'h13, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
                         OPC_BRANCH = 7'h63, OPC_JAL = 7'h6f, OPC_JALR = 7'h67, OPC_LUI = 7'h37,
                         OPC_AUIPC = 7'h17, OPC_FENCE = 7'h0f, OPC_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_XOR = 4'd5,
    ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASS_B = 4'd10
  } alu_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [3:0]      alu_op;
    logic            src_a, src_b, reg_write, mem_read, mem_write, branch, jal, jalr, illegal;
  } idex_t;

  logic [XLEN-1:0] r_regs [NREGS];
  idex_t           r_idex, w_dec;
  logic [31:0]     w_inst;
  logic [6:0]      w_opc, w_f7;
  logic [2:0]      w_f3;
  logic [4:0]      w_rs1, w_rs2;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic            w_wr, w_legal, w_uses_rs1, w_uses_rs2, w_hazard;
  alu_e            w_alu_rr;

  assign w_inst = id_bus.if_inst;
  assign w_opc  = w_inst[6:0];
  assign w_f3   = w_inst[14:12];
  assign w_f7   = w_inst[31:25];
  assign w_rs1  = w_inst[19:15];
  assign w_rs2  = w_inst[24:20];

  // Register file; x0 is never written so its storage stays at the reset value.
  assign w_wr = id_bus.wb_en && (id_bus.wb_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[id_bus.wb_rd] <= id_bus.wb_data;
    end
  end

  assign w_rs1_data = (w_rs1 == 5'd0) ? '0 :
                      (w_wr && id_bus.wb_rd == w_rs1) ? id_bus.wb_data : r_regs[w_rs1];
  assign w_rs2_data = (w_rs2 == 5'd0) ? '0 :
                      (w_wr && id_bus.wb_rd == w_rs2) ? id_bus.wb_data : r_regs[w_rs2];

  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'b0};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  // inst[30] selects SUB/SRA; OP-IMM only honours it for the shift encodings.
  always_comb begin
    w_alu_rr = ALU_ADD;
    case (w_f3)
      3'b000:  w_alu_rr = w_f7[5] ? ALU_SUB : ALU_ADD;
      3'b001:  w_alu_rr = ALU_SLL;
      3'b010:  w_alu_rr = ALU_SLT;
      3'b011:  w_alu_rr = ALU_SLTU;
      3'b100:  w_alu_rr = ALU_XOR;
      3'b101:  w_alu_rr = w_f7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  w_alu_rr = ALU_OR;
      default: w_alu_rr = ALU_AND;
    endcase
  end

  always_comb begin
    w_dec          = '0;
    w_legal        = 1'b1;
    w_dec.valid    = 1'b1;
    w_dec.pc       = id_bus.if_pc;
    w_dec.rs1      = w_rs1;
    w_dec.rs2      = w_rs2;
    w_dec.rd       = w_inst[11:7];
    w_dec.rs1_data = w_rs1_data;
    w_dec.rs2_data = w_rs2_data;
    w_dec.funct3   = w_f3;
    case (w_opc)
      OPC_OP: begin
        w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101));
        w_dec.alu_op = w_alu_rr;
        w_dec.reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        if (w_f3 == 3'b001)      w_legal = (w_f7 == 7'h00);
        else if (w_f3 == 3'b101) w_legal = (w_f7 == 7'h00) || (w_f7 == 7'h20);
        w_dec.alu_op = (w_f3 == 3'b000) ? ALU_ADD : w_alu_rr;
        w_dec.imm = w_imm_i; w_dec.src_b = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        w_dec.imm = w_imm_i; w_dec.src_b = 1'b1; w_dec.mem_read = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        w_dec.imm = w_imm_s; w_dec.src_b = 1'b1; w_dec.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        w_dec.imm = w_imm_b; w_dec.src_a = 1'b1; w_dec.src_b = 1'b1; w_dec.branch = 1'b1;
      end
      OPC_JAL: begin
        w_dec.imm = w_imm_j; w_dec.src_a = 1'b1; w_dec.src_b = 1'b1;
        w_dec.jal = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        w_dec.imm = w_imm_i; w_dec.src_b = 1'b1; w_dec.jalr = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_LUI: begin
        w_dec.alu_op = ALU_PASS_B; w_dec.imm = w_imm_u; w_dec.src_b = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec.imm = w_imm_u; w_dec.src_a = 1'b1; w_dec.src_b = 1'b1; w_dec.reg_write = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: w_dec.imm = w_imm_i;
      default: w_legal = 1'b0;
    endcase
    // All-zero word is the fetch reset value: a quiet bubble, not an illegal instruction.
    if (w_inst == 32'h0) begin
      w_dec = '0;
    end else if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
  end

  assign w_uses_rs1 = (w_opc == OPC_OP) || (w_opc == OPC_OPIMM) || (w_opc == OPC_LOAD) ||
                      (w_opc == OPC_STORE) || (w_opc == OPC_BRANCH) || (w_opc == OPC_JALR);
  assign w_uses_rs2 = (w_opc == OPC_OP) || (w_opc == OPC_STORE) || (w_opc == OPC_BRANCH);
  assign w_hazard   = r_idex.valid && r_idex.mem_read && (r_idex.rd != 5'd0) &&
                      ((w_uses_rs1 && w_rs1 == r_idex.rd) || (w_uses_rs2 && w_rs2 == r_idex.rd));
  assign id_bus.stall_req = w_hazard && !id_bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_idex <= '0;
    else if (id_bus.clk_en) begin
      if (id_bus.flush || w_hazard)      r_idex <= '0;
      else                               r_idex <= w_dec;
    end
  end

  assign id_bus.id_valid     = r_idex.valid;
  assign id_bus.id_pc        = r_idex.pc;
  assign id_bus.id_rs1_data  = r_idex.rs1_data;
  assign id_bus.id_rs2_data  = r_idex.rs2_data;
  assign id_bus.id_imm       = r_idex.imm;
  assign id_bus.id_rs1       = r_idex.rs1;
  assign id_bus.id_rs2       = r_idex.rs2;
  assign id_bus.id_rd        = r_idex.rd;
  assign id_bus.id_funct3    = r_idex.funct3;
  assign id_bus.id_alu_op    = r_idex.alu_op;
  assign id_bus.id_alu_src_a = r_idex.src_a;
  assign id_bus.id_alu_src_b = r_idex.src_b;
  assign id_bus.id_reg_write = r_idex.reg_write;
  assign id_bus.id_mem_read  = r_idex.mem_read;
  assign id_bus.id_mem_write = r_idex.mem_write;
  assign id_bus.id_branch    = r_idex.branch;
  assign id_bus.id_jal       = r_idex.jal;
  assign id_bus.id_jalr      = r_idex.jalr;
  assign id_bus.illegal_inst = r_idex.illegal;
endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus randomized traffic,
// all compared against a behavioural ID/EX and register-file model.
module tb_instruction_decode;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_decode_if bus();
  instruction_decode dut (.clk(clk), .rst_n(rst_n), .id_bus(bus.slave));

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        sa, sb, rw, mr, mw, br, jal, jalr, ill;
  } bund_t;

  int          checks = 0;
  int          errors = 0;
  bund_t       m;
  logic [31:0] mregs [32];
  logic        m_stall;

  function automatic bund_t dut_bund();
    bund_t b;
    b.valid = bus.id_valid; b.pc = bus.id_pc; b.rs1d = bus.id_rs1_data; b.rs2d = bus.id_rs2_data;
    b.imm = bus.id_imm; b.rs1 = bus.id_rs1; b.rs2 = bus.id_rs2; b.rd = bus.id_rd;
    b.f3 = bus.id_funct3; b.alu = bus.id_alu_op; b.sa = bus.id_alu_src_a; b.sb = bus.id_alu_src_b;
    b.rw = bus.id_reg_write; b.mr = bus.id_mem_read; b.mw = bus.id_mem_write; b.br = bus.id_branch;
    b.jal = bus.id_jal; b.jalr = bus.id_jalr; b.ill = bus.illegal_inst;
    return b;
  endfunction

  // Architectural read: the value the register holds once this cycle's writeback lands.
  function automatic logic [31:0] rdreg(logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
    return mregs[idx];
  endfunction

  function automatic logic [31:0] sext(logic [31:0] v, int bits);
    logic [31:0] sh;
    sh = 32 - bits;
    return 32'($signed(v << sh) >>> sh);
  endfunction

  function automatic bund_t model_decode(logic [31:0] inst, logic [31:0] pc);
    bund_t       b;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  alu_tab [16];
    logic        legal;
    alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9,
                4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0};
    op = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    b = '0;
    if (inst == 0) return b;
    legal = 1'b1;
    b.valid = 1; b.pc = pc; b.rs1 = inst[19:15]; b.rs2 = inst[24:20]; b.rd = inst[11:7];
    b.rs1d = rdreg(inst[19:15]); b.rs2d = rdreg(inst[24:20]); b.f3 = f3;
    case (op)
      7'h33: begin
        legal = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        b.alu = alu_tab[{f7[5], f3}]; b.rw = 1;
      end
      7'h13: begin
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        b.alu = (f3 == 5) ? alu_tab[{f7[5], f3}] : alu_tab[{1'b0, f3}];
        b.imm = sext(32'(inst[31:20]), 12); b.sb = 1; b.rw = 1;
      end
      7'h03: begin b.imm = sext(32'(inst[31:20]), 12); b.sb = 1; b.mr = 1; b.rw = 1; end
      7'h23: begin b.imm = sext(32'({inst[31:25], inst[11:7]}), 12); b.sb = 1; b.mw = 1; end
      7'h63: begin
        b.imm = sext(32'({inst[31], inst[7], inst[30:25], inst[11:8]}) * 2, 13);
        b.sa = 1; b.sb = 1; b.br = 1;
      end
      7'h6f: begin
        b.imm = sext(32'({inst[31], inst[19:12], inst[20], inst[30:21]}) * 2, 21);
        b.sa = 1; b.sb = 1; b.jal = 1; b.rw = 1;
      end
      7'h67: begin b.imm = sext(32'(inst[31:20]), 12); b.sb = 1; b.jalr = 1; b.rw = 1; end
      7'h37: begin b.alu = 4'd10; b.imm = 32'(inst[31:12]) * 4096; b.sb = 1; b.rw = 1; end
      7'h17: begin b.imm = 32'(inst[31:12]) * 4096; b.sa = 1; b.sb = 1; b.rw = 1; end
      7'h0f, 7'h73: b.imm = sext(32'(inst[31:20]), 12);
      default: legal = 1'b0;
    endcase
    if (!legal) begin b = '0; b.ill = 1; end
    return b;
  endfunction

  function automatic logic model_hazard();
    logic [6:0] op;
    logic       u1, u2;
    op = bus.if_inst[6:0];
    u1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
    u2 = op inside {7'h33, 7'h23, 7'h63};
    return m.valid && m.mr && m.rd != 0 &&
           ((u1 && bus.if_inst[19:15] == m.rd) || (u2 && bus.if_inst[24:20] == m.rd));
  endfunction

  // One clock: check stall_req before the edge, advance the model, check the bundle after it.
  task automatic step();
    bund_t nxt;
    logic  hz;
    #1;
    hz = model_hazard();
    m_stall = hz && !bus.flush;
    checks++;
    if (bus.stall_req !== m_stall) begin
      errors++;
      $display("FAIL stall_req t=%0t: got %b exp %b", $time, bus.stall_req, m_stall);
    end
    nxt = m;
    if (bus.clk_en) nxt = (bus.flush || hz) ? bund_t'('0) : model_decode(bus.if_inst, bus.if_pc);
    if (bus.wb_en && bus.wb_rd != 0) mregs[bus.wb_rd] = bus.wb_data;
    @(posedge clk); #1;
    m = nxt;
    checks++;
    if (dut_bund() !== m) begin
      errors++;
      $display("FAIL idex_bundle t=%0t: got %h exp %h", $time, dut_bund(), m);
    end
    @(negedge clk);
  endtask

  task automatic drive(logic [31:0] inst, logic [31:0] pc);
    bus.if_inst = inst; bus.if_pc = pc;
  endtask

  task automatic test_reset();
    rst_n = 0;
    bus.clk_en = 1; bus.flush = 0; bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
    drive(32'h0, 32'h0);
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (dut_bund() !== bund_t'('0) || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %h stall %b exp all zero", dut_bund(), bus.stall_req);
    end
    @(negedge clk);
  endtask

  task automatic test_addi();
    drive(32'h00500093, 32'h10);
    step();
    checks++;
    if (bus.id_valid !== 1 || bus.id_rd !== 5'd1 || bus.id_imm !== 32'd5 || bus.id_alu_op !== 4'd0 ||
        bus.id_alu_src_b !== 1 || bus.id_reg_write !== 1 || bus.id_pc !== 32'h10) begin
      errors++;
      $display("FAIL addi: got v%b rd%0d imm%h alu%0d sb%b rw%b pc%h", bus.id_valid, bus.id_rd,
               bus.id_imm, bus.id_alu_op, bus.id_alu_src_b, bus.id_reg_write, bus.id_pc);
    end
  endtask

  task automatic test_branch();
    drive(32'hFE000CE3, 32'h14);
    step();
    checks++;
    if (bus.id_imm !== 32'hFFFFFFF8 || bus.id_branch !== 1 || bus.id_alu_src_a !== 1 ||
        bus.id_reg_write !== 0) begin
      errors++;
      $display("FAIL beq: got imm %h br %b sa %b rw %b exp fffffff8 1 1 0",
               bus.id_imm, bus.id_branch, bus.id_alu_src_a, bus.id_reg_write);
    end
  endtask

  task automatic test_load_use();
    int stalls = 0;
    drive(32'h0000A103, 32'h20);
    step();
    drive(32'h001101B3, 32'h24);
    for (int i = 0; i < 4 && !(bus.id_valid && bus.id_rd == 5'd3); i++) begin
      #1;
      if (bus.stall_req) stalls++;
      step();
    end
    checks++;
    if (stalls != 1 || bus.id_valid !== 1 || bus.id_rd !== 5'd3) begin
      errors++;
      $display("FAIL load_use: got stalls %0d valid %b rd %0d exp 1 1 3", stalls, bus.id_valid, bus.id_rd);
    end
  endtask

  task automatic test_bypass();
    bus.wb_en = 1; bus.wb_rd = 5; bus.wb_data = 32'hDEADBEEF;
    drive(32'h00028333, 32'h30);
    step();
    checks++;
    if (bus.id_rs1_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bypass: got %h exp deadbeef", bus.id_rs1_data);
    end
    bus.wb_rd = 0; bus.wb_data = 32'h1234;
    drive(32'h00000333, 32'h34);
    step();
    bus.wb_en = 0;
    step();
    checks++;
    if (bus.id_rs1_data !== 32'h0 || bus.id_rs2_data !== 32'h0) begin
      errors++;
      $display("FAIL x0_write: got %h %h exp 0 0", bus.id_rs1_data, bus.id_rs2_data);
    end
  endtask

  task automatic test_flush_illegal();
    drive(32'h0000A103, 32'h40);
    step();
    drive(32'h001101B3, 32'h44);
    bus.flush = 1;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b exp 0", bus.stall_req);
    end
    step();
    bus.flush = 0;
    checks++;
    if (bus.id_valid !== 0 || bus.illegal_inst !== 0 || bus.id_reg_write !== 0) begin
      errors++;
      $display("FAIL flush_bubble: got v%b ill%b rw%b exp 0 0 0", bus.id_valid, bus.illegal_inst, bus.id_reg_write);
    end
    drive(32'h0000007F, 32'h48);
    step();
    checks++;
    if (bus.illegal_inst !== 1 || bus.id_valid !== 0) begin
      errors++;
      $display("FAIL illegal: got ill %b valid %b exp 1 0", bus.illegal_inst, bus.id_valid);
    end
  endtask

  task automatic test_clk_en();
    drive(32'h00500093, 32'h10);
    step();
    bus.clk_en = 0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom);
      step();
      checks++;
      if (bus.id_valid !== 1 || bus.id_rd !== 5'd1 || bus.id_imm !== 32'd5 || bus.id_pc !== 32'h10) begin
        errors++;
        $display("FAIL hold_%0d: got v%b rd%0d imm%h pc%h exp 1 1 5 10", i, bus.id_valid, bus.id_rd,
                 bus.id_imm, bus.id_pc);
      end
    end
    bus.clk_en = 1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops [12];
    logic [31:0] r;
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73, 7'h7f};
    r = $urandom;
    k = $urandom_range(0, 13);
    if (k == 13) return 32'h0;
    r[6:0] = ops[k];
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    if (k <= 1) begin
      case ($urandom_range(0, 3))
        0, 1:    r[31:25] = 7'h00;
        2:       r[31:25] = 7'h20;
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic test_random();
    logic [31:0] inst, pc;
    inst = rand_inst(); pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      drive(inst, pc);
      bus.flush   = ($urandom_range(0, 9) == 0);
      bus.clk_en  = ($urandom_range(0, 6) != 0);
      bus.wb_en   = $urandom_range(0, 1);
      bus.wb_rd   = 5'($urandom_range(0, 7));
      bus.wb_data = $urandom;
      step();
      if (!m_stall && bus.clk_en) begin inst = rand_inst(); pc = pc + 4; end
    end
    bus.flush = 0; bus.clk_en = 1; bus.wb_en = 0;
  endtask

  task automatic test_reset_mid();
    bus.wb_en = 1; bus.wb_rd = 1; bus.wb_data = 32'h55;
    drive(32'h00500093, 32'h50);
    step();
    bus.wb_en = 0;
    step();
    #2 rst_n = 0;
    #1;
    checks++;
    if (dut_bund() !== bund_t'('0) || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %h exp all zero", dut_bund());
    end
    m = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    drive(32'h00008333, 32'h60);
    rst_n = 1;
    step();
    checks++;
    if (bus.id_rs1_data !== 32'h0 || bus.id_valid !== 1) begin
      errors++;
      $display("FAIL x1_after_reset: got %h valid %b exp 0 1", bus.id_rs1_data, bus.id_valid);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_load_use();
    test_bypass();
    test_flush_illegal();
    test_clk_en();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Second stage of the RV32I 5-stage pipeline. Consumes if_inst/if_pc from instruction fetch and feeds the execute stage through a registered ID/EX boundary.
- Contains the 32x32 integer register file (read in ID, written from writeback) and the immediate generator.
- Produces the control bundle for the execute stage.
- Detects load-use hazards and requests a fetch stall.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- NREGS, 32, register count (x0 is hardwired to zero).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- clk_en  in  1  pipeline advance enable; 0 holds all ID/EX registers
- flush  in  1  branch/jump taken in EX; squash the instruction in ID
- if_inst  in  32  instruction from fetch
- if_pc  in  32  PC of if_inst
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback destination
- wb_data  in  32  writeback value
- stall_req  out  1  load-use hazard; top level drives fetch clk_en = clk_en & ~stall_req
- id_valid  out  1  ID/EX slot holds a real instruction
- id_pc  out  32  PC of the decoded instruction
- id_rs1_data, id_rs2_data  out  32 each  operand values
- id_imm  out  32  sign-extended immediate
- id_rs1, id_rs2, id_rd  out  5 each  register indices
- id_funct3  out  3  for branch compare and load/store size in EX/MEM
- id_alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B
- id_alu_src_a  out  1  0 = rs1, 1 = PC
- id_alu_src_b  out  1  0 = rs2, 1 = imm
- id_reg_write, id_mem_read, id_mem_write, id_branch, id_jal, id_jalr  out  1 each  control
- illegal_inst  out  1  decoded opcode/funct is unsupported

Behaviour:
- Reset (asynchronous): all ID/EX outputs are 0 and all registers x0..x31 are 0. stall_req is combinational and is 0 after reset because id_valid = 0.

Register file:
- Writes at posedge when wb_en && wb_rd != 0, independent of clk_en and flush.
- Writes to x0 are ignored; reads of x0 return 0.
- Reads are combinational from if_inst[19:15] and if_inst[24:20].
- Write-first bypass: if wb_en && wb_rd != 0 && wb_rd matches the read index in the same cycle, the read returns wb_data.

Decode (combinational, then registered at posedge when clk_en):
- Immediate formats:
  - I: inst[31:20] sign-extended
  - S: {inst[31:25], inst[11:7]}
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - All signed formats sign-extend from inst[31].
- OP (0110011): alu_op from funct3/funct7. funct7 must be 0000000, or 0100000 only for SUB/SRA; anything else is illegal. src_b = rs2, reg_write = 1.
- OP-IMM (0010011): src_b = imm. SLLI/SRLI/SRAI use the funct7 rule; alu_op uses inst[30] only for shifts.
- LOAD (0000011): ADD, src_b = imm, mem_read = 1, reg_write = 1.
- STORE (0100011): ADD, S-imm, mem_write = 1.
- BRANCH (1100011): ADD, src_a = PC, B-imm, branch = 1.
- JAL: ADD, src_a = PC, J-imm, jal = 1, reg_write = 1.
- JALR: ADD, rs1 + I-imm, jalr = 1, reg_write = 1. EX computes the link value as id_pc + 4.
- LUI: PASS_B, U-imm. AUIPC: ADD, src_a = PC, U-imm. Both set reg_write = 1.
- FENCE/SYSTEM: id_valid = 1 with all side-effect controls 0 (NOP).
- if_inst == 32'h0 (fetch reset value): bubble, with id_valid = 0 and illegal_inst = 0.
- Any other opcode: illegal_inst = 1, id_valid = 0, all controls 0.

Hazard:
- hazard = id_valid && id_mem_read && id_rd != 0 && ((uses_rs1 && rs1 == id_rd) || (uses_rs2 && rs2 == id_rd)).
- uses_rs1: OP, OP-IMM, LOAD, STORE, BRANCH, JALR. uses_rs2: OP, STORE, BRANCH.
- stall_req = hazard && !flush.

Update priority at posedge with clk_en = 1:
1. flush: load a bubble (id_valid = 0, all controls, illegal_inst and alu_op 0; data fields don't-care but driven 0).
2. hazard: load a bubble; fetch holds, so the same if_inst is re-decoded next cycle.
3. Otherwise: load the decoded instruction.

clk_en = 0: all ID/EX registers hold. stall_req is still evaluated from the held values.

Reset mid-operation: outputs and register file clear immediately (asynchronous).

Latency: 1 cycle from if_inst to id_* outputs.

Test Plan:
- ADDI x1,x0,5 (0x00500093), if_pc = 0x10 -> next cycle: id_valid = 1, id_rd = 1, id_imm = 5, alu_op = 0, src_b = 1, reg_write = 1, id_pc = 0x10.
- BEQ x0,x0,-8 (0xFE000CE3) -> id_imm = 0xFFFFFFF8, id_branch = 1, src_a = 1, reg_write = 0.
- LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x1 (0x001101B3) -> stall_req = 1 for exactly one cycle; one bubble enters ID/EX; then ADD issues with id_valid = 1.
- Bypass: wb_en = 1, wb_rd = 5, wb_data = 0xDEADBEEF in the same cycle as ADD x6,x5,x0 -> id_rs1_data = 0xDEADBEEF. A write with wb_rd = 0 followed by a read of x0 -> 0.
- flush = 1 together with a hazard -> stall_req = 0, bubble loaded. Opcode 0x7F -> illegal_inst = 1, id_valid = 0.
- clk_en = 0 for 3 cycles -> id_* outputs stable. Assert rst_n low mid-stream -> all outputs 0 immediately and x1 reads 0 afterwards.
